// File: rtl/btn_bcd_counter.sv
// -----------------------------------------------------------------------------
// btn_bcd_counter
//
// Multi-digit decimal up/down counter driven by two raw push-buttons.
// Each button is synchronised (2 flops), polarity-corrected, debounced, and
// turned into a one-cycle step pulse on every press. The step pulses drive a
// BCD counter with ripple carry/borrow across all digits, and every digit is
// decoded to an active-high 7-segment pattern.
//
// Optional feature (compile-time macro):
//   HOLD_REPEAT_EN  - when defined, holding a button auto-repeats: one extra
//                     step REPEAT_DELAY cycles after the press step, then one
//                     every REPEAT_PERIOD cycles while still held. When
//                     undefined, no repeat counters exist and each press
//                     gives exactly one step.
//
// Parameters:
//   DIGITS           number of BCD digits (1..8)
//   DEBOUNCE_CYCLES  consecutive stable cycles before a level is accepted (>=2)
//   BTN_ACTIVE_LOW   1: raw button reads 0 when pressed; 0: reads 1
//   REPEAT_DELAY     hold cycles before auto-repeat starts (>=1)
//   REPEAT_PERIOD    cycles between auto-repeat steps (>=1)
//
// Ports:
//   clk     in   1         single clock, rising edge
//   rst     in   1         asynchronous, active-high reset
//   btn_up  in   1         raw asynchronous increment button
//   btn_dn  in   1         raw asynchronous decrement button
//   count   out  4*DIGITS  BCD value, digit 0 (ones) in bits [3:0]
//   seg     out  7*DIGITS  per-digit segments, digit 0 in bits [6:0],
//                          bit0=a .. bit6=g, active-high
//   wrap    out  1         one-cycle pulse when the count wraps either way
// -----------------------------------------------------------------------------
module btn_bcd_counter #(
  parameter int DIGITS          = 2,
  parameter int DEBOUNCE_CYCLES = 1200000,
  parameter int BTN_ACTIVE_LOW  = 1,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 12000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_up,
  input  logic                  btn_dn,
  output logic [4*DIGITS-1:0]   count,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  wrap
);

  // Elaboration-time sanity check of the parameter ranges.
  if (DIGITS < 1 || DIGITS > 8 || DEBOUNCE_CYCLES < 2 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("btn_bcd_counter: parameter out of range");
  end

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Raw level that means "not pressed"; synchronisers reset to it so a button
  // held through reset release is seen as a fresh press.
  localparam logic RELEASED_RAW = (BTN_ACTIVE_LOW != 0);

`ifdef HOLD_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);
`endif

  logic [1:0] btn_raw;
  logic [1:0] step;     // [0] = up step, [1] = down step

  assign btn_raw = {btn_dn, btn_up};

  // ---------------------------------------------------------------------------
  // Per-button conditioning: synchroniser, debounce, press-edge step pulse.
  // ---------------------------------------------------------------------------
  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic [1:0]      sync_q;
    logic            synced_pressed;
    logic            accepted;
    logic            accepted_q;
    logic [DB_W-1:0] db_cnt;
    logic            press_rise;
    logic            step_q;

    assign synced_pressed = sync_q[1] ^ RELEASED_RAW;
    assign press_rise     = accepted & ~accepted_q;
    assign step[b]        = step_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values and the block order does not matter.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_q     <= {2{RELEASED_RAW}};
        accepted   <= 1'b0;
        accepted_q <= 1'b0;
        db_cnt     <= '0;
      end else begin
        sync_q     <= {sync_q[0], btn_raw[b]};
        accepted_q <= accepted;
        // The counter only runs while the synced level disagrees with the
        // accepted one; any agreeing cycle restarts the qualification.
        if (synced_pressed == accepted) begin
          db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
          accepted <= synced_pressed;
          db_cnt   <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end
    end

`ifdef HOLD_REPEAT_EN
    logic [REP_W-1:0] rep_cnt;
    logic             rep_first;  // still waiting for the first (long) delay
    logic             rep_fire;

    // rep_cnt is cleared on the press edge, so it measures cycles since the
    // press step was issued.
    assign rep_fire = accepted & accepted_q &
                      (rep_cnt == (rep_first ? DELAY_LAST : PERIOD_LAST));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rep_cnt   <= '0;
        rep_first <= 1'b1;
        step_q    <= 1'b0;
      end else begin
        step_q <= press_rise | rep_fire;
        if (!accepted || press_rise) begin
          rep_cnt   <= '0;
          rep_first <= 1'b1;
        end else if (rep_fire) begin
          rep_cnt   <= '0;
          rep_first <= 1'b0;
        end else begin
          rep_cnt <= rep_cnt + 1'b1;
        end
      end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        step_q <= 1'b0;
      end else begin
        step_q <= press_rise;
      end
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // BCD increment / decrement candidates with ripple carry / borrow.
  // ---------------------------------------------------------------------------
  logic [4*DIGITS-1:0] count_inc;
  logic [4*DIGITS-1:0] count_dec;
  logic                inc_wraps;
  logic                dec_wraps;

  // NOTE: every output of an always_comb gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    logic carry;
    logic borrow;
    count_inc = count;
    count_dec = count;
    carry     = 1'b1;
    borrow    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count[4*i +: 4] == 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
      if (borrow) begin
        if (count[4*i +: 4] == 4'd0) begin
          count_dec[4*i +: 4] = 4'd9;
        end else begin
          count_dec[4*i +: 4] = count[4*i +: 4] - 4'd1;
          borrow              = 1'b0;
        end
      end
    end
    // A carry/borrow that ripples out of the top digit is a wrap-around.
    inc_wraps = carry;
    dec_wraps = borrow;
  end

  // Simultaneous up and down steps cancel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (step[0] && !step[1]) begin
        count <= count_inc;
        wrap  <= inc_wraps;
      end else if (step[1] && !step[0]) begin
        count <= count_dec;
        wrap  <= dec_wraps;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // 7-segment decode, purely combinational from count.
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'h3F;
      4'd1:    seg_of = 7'h06;
      4'd2:    seg_of = 7'h5B;
      4'd3:    seg_of = 7'h4F;
      4'd4:    seg_of = 7'h66;
      4'd5:    seg_of = 7'h6D;
      4'd6:    seg_of = 7'h7D;
      4'd7:    seg_of = 7'h07;
      4'd8:    seg_of = 7'h7F;
      4'd9:    seg_of = 7'h6F;
      default: seg_of = 7'h00;  // unreachable: count holds only legal BCD
    endcase
  endfunction

  always_comb begin
    seg = '0;
    for (int i = 0; i < DIGITS; i++) begin
      seg[7*i +: 7] = seg_of(count[4*i +: 4]);
    end
  end

endmodule
